// File: rtl/vga_timing_pkg.sv
// Default VGA timing sets (640x480@60, 800x600@60) and helpers deriving
// axis totals and active-area start offsets.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned active;
    int unsigned front;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{sync: 96,  back: 48, active: 640, front: 16};
  localparam axis_timing_t VGA640_V = '{sync: 2,   back: 33, active: 480, front: 10};
  localparam axis_timing_t SVGA_H   = '{sync: 128, back: 88, active: 800, front: 40};
  localparam axis_timing_t SVGA_V   = '{sync: 4,   back: 23, active: 600, front: 1};

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.sync + t.back + t.active + t.front;
  endfunction

  function automatic int unsigned axis_active_start(axis_timing_t t);
    return t.sync + t.back;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: a wrapping position counter with sync/active decode and
// active-relative coordinate. Decodes are combinational from the counter.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned W      = 11,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_c,
  output logic         sync_n_c,
  output logic         active_c,
  output logic [W-1:0] coord_c
);

  localparam axis_timing_t T   = '{sync: SYNC, back: BACK, active: ACTIVE, front: FRONT};
  localparam int unsigned TOTAL = axis_total(T);
  localparam int unsigned A0    = axis_active_start(T);
  localparam int unsigned A1    = A0 + ACTIVE;

  if (TOTAL > 2**W) begin : g_total_check
    $error("vga_axis_timer: total %0d does not fit in %0d bits", TOTAL, W);
  end

  logic [W-1:0] count_q, count_d;
  logic [W:0]   count_x;

  // Compares run one bit wider so an axis filling all 2^W positions still decodes.
  assign count_x  = {1'b0, count_q};
  assign wrap_c   = (count_x == (W+1)'(TOTAL - 1));
  assign sync_n_c = !(count_x < (W+1)'(SYNC));
  assign active_c = (count_x >= (W+1)'(A0)) && (count_x < (W+1)'(A1));
  assign coord_c  = active_c ? (count_q - W'(A0)) : '0;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_c ? '0 : (count_q + W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator with a per-frame shadowed overlay window.
// All outputs are registered and reflect the counter value of the previous pix_ce cycle.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned W        = 11,
  parameter int unsigned H_SYNC   = VGA640_H.sync,
  parameter int unsigned H_BACK   = VGA640_H.back,
  parameter int unsigned H_ACTIVE = VGA640_H.active,
  parameter int unsigned H_FRONT  = VGA640_H.front,
  parameter int unsigned V_SYNC   = VGA640_V.sync,
  parameter int unsigned V_BACK   = VGA640_V.back,
  parameter int unsigned V_ACTIVE = VGA640_V.active,
  parameter int unsigned V_FRONT  = VGA640_V.front,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pix_ce,
  input  logic [W-1:0] win_x,
  input  logic [W-1:0] win_y,
  input  logic [W-1:0] win_w,
  input  logic [W-1:0] win_h,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [W-1:0] col,
  output logic [W-1:0] row,
  output logic         line_start,
  output logic         frame_start,
  output logic         in_win,
  output logic [W-1:0] win_col,
  output logic [W-1:0] win_row
);

  logic [W-1:0] h_count, v_count, h_coord, v_coord;
  logic         h_wrap, h_sync_n, h_active;
  logic         v_wrap_unused, v_sync_n, v_active;
  logic         v_inc;

  assign v_inc = h_wrap & pix_ce;

  vga_axis_timer #(
    .W(W), .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
  ) u_h_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (pix_ce),
    .count_o  (h_count),
    .wrap_c   (h_wrap),
    .sync_n_c (h_sync_n),
    .active_c (h_active),
    .coord_c  (h_coord)
  );

  vga_axis_timer #(
    .W(W), .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
  ) u_v_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (v_inc),
    .count_o  (v_count),
    .wrap_c   (v_wrap_unused),
    .sync_n_c (v_sync_n),
    .active_c (v_active),
    .coord_c  (v_coord)
  );

  logic         hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic         line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic         in_win_q, in_win_d;
  logic [W-1:0] col_q, col_d, row_q, row_d, win_col_q, win_col_d, win_row_q, win_row_d;
  logic [W-1:0] sx_q, sx_d, sy_q, sy_d, sw_q, sw_d, sh_q, sh_d;
  logic [W:0]   x_end, y_end;

  // Output decode and shadow reload; window bounds summed at W+1 bits to avoid wrap.
  always_comb begin
    hsync_d       = h_sync_n ? ~HS_POL : HS_POL;
    vsync_d       = v_sync_n ? ~VS_POL : VS_POL;
    de_d          = h_active && v_active;
    col_d         = de_d ? h_coord : '0;
    row_d         = de_d ? v_coord : '0;
    line_start_d  = (h_count == '0);
    frame_start_d = line_start_d && (v_count == '0);
    x_end         = {1'b0, sx_q} + {1'b0, sw_q};
    y_end         = {1'b0, sy_q} + {1'b0, sh_q};
    in_win_d      = de_d
                    && (col_d >= sx_q) && ({1'b0, col_d} < x_end)
                    && (row_d >= sy_q) && ({1'b0, row_d} < y_end);
    win_col_d     = in_win_d ? (col_d - sx_q) : '0;
    win_row_d     = in_win_d ? (row_d - sy_q) : '0;
    sx_d          = frame_start_d ? win_x : sx_q;
    sy_d          = frame_start_d ? win_y : sy_q;
    sw_d          = frame_start_d ? win_w : sw_q;
    sh_d          = frame_start_d ? win_h : sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      in_win_q      <= 1'b0;
      win_col_q     <= '0;
      win_row_q     <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      sw_q          <= '0;
      sh_q          <= '0;
    end else if (pix_ce) begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      in_win_q      <= in_win_d;
      win_col_q     <= win_col_d;
      win_row_q     <= win_row_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      sw_q          <= sw_d;
      sh_q          <= sh_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign col         = col_q;
  assign row         = row_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign in_win      = in_win_q;
  assign win_col     = win_col_q;
  assign win_row     = win_row_q;

endmodule
